// File: rtl/csc_pkg.sv
// Shared encodings and defaults for the CSC sequence generator and its credit logic.
package csc_pkg;

    localparam int unsigned CSC_CNT_W      = 14;
    localparam int unsigned CSC_CREDIT_W   = 9;
    localparam int unsigned CSC_CREDIT_MAX = 256;

    typedef enum logic [1:0] {
        CSC_IDLE = 2'd0,
        CSC_PEND = 2'd1,
        CSC_BUSY = 2'd2,
        CSC_DONE = 2'd3
    } csc_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_WT,
        S_DL,
        S_DRAIN,
        S_DONE
    } sg_state_e;

endpackage

// File: rtl/csc_sg_credit.sv
// CACC credit counter: return/consume applied together, saturating at CREDIT_MAX with sticky error.
module csc_sg_credit
    import csc_pkg::*;
#(
    parameter int unsigned CREDIT_W   = CSC_CREDIT_W,
    parameter int unsigned CREDIT_MAX = CSC_CREDIT_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ret_vld,
    input  logic [2:0]          ret_size,
    input  logic                consume,
    output logic [CREDIT_W-1:0] credit,
    output logic                credit_err
);

    localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(CREDIT_MAX);

    logic [CREDIT_W:0] sum;

    // One extra bit so an over-return is caught rather than wrapping.
    always_comb begin
        sum = {1'b0, credit}
            + (ret_vld ? (CREDIT_W+1)'(ret_size) : '0)
            - (CREDIT_W+1)'(consume);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit     <= CREDIT_W'(CREDIT_MAX);
            credit_err <= 1'b0;
        end else if (sum > MAX_EXT) begin
            credit     <= CREDIT_W'(CREDIT_MAX);
            credit_err <= 1'b1;
        end else begin
            credit     <= sum[CREDIT_W-1:0];
        end
    end

endmodule

// File: rtl/csc_sg_seq.sv
// CSC sequence generator: per-group weight/data atom issue, credit-throttled data, and
// the pending_clr / fifo_clr / done handshakes around a layer.
module csc_sg_seq
    import csc_pkg::*;
#(
    parameter int unsigned CNT_W      = CSC_CNT_W,
    parameter int unsigned CREDIT_W   = CSC_CREDIT_W,
    parameter int unsigned CREDIT_MAX = CSC_CREDIT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       csc_state,
    input  logic [CNT_W-1:0] cfg_groups,
    input  logic [CNT_W-1:0] cfg_wt_atoms,
    input  logic [CNT_W-1:0] cfg_dl_atoms,
    input  logic             cbuf_pend_ack,
    input  logic             wt_rdy,
    input  logic             dl_rdy,
    input  logic             credit_vld,
    input  logic [2:0]       credit_size,
    input  logic             cacc_done,
    output logic             pending_clr,
    output logic             sg2wt_vld,
    output logic             sg2dl_vld,
    output logic             fifo_clr,
    output logic             done,
    output logic             credit_err,
    output logic             busy
);

    sg_state_e state, state_nxt;

    logic [CNT_W-1:0]    wt_cnt, dl_cnt, grp_cnt;
    logic [CNT_W-1:0]    cfg_groups_q, cfg_wt_q, cfg_dl_q;
    logic [CNT_W-1:0]    wt_cnt_inc, dl_cnt_inc;
    logic [CREDIT_W-1:0] credit;
    logic                ack_seen, cacc_done_seen;
    logic                wt_xfer, dl_xfer;
    logic                latch_cfg, grp_adv;
    logic                pend_set, fifo_set, done_set;
    logic                csc_busy;

    csc_sg_credit #(
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .ret_vld    (credit_vld),
        .ret_size   (credit_size),
        .consume    (dl_xfer),
        .credit     (credit),
        .credit_err (credit_err)
    );

    assign csc_busy   = (csc_state == CSC_BUSY);
    assign busy       = (state != S_IDLE);
    assign sg2wt_vld  = (state == S_WT) && (cfg_groups_q != '0) && (wt_cnt < cfg_wt_q);
    assign sg2dl_vld  = (state == S_DL) && (dl_cnt < cfg_dl_q) && (credit != '0);
    assign wt_xfer    = sg2wt_vld && wt_rdy;
    assign dl_xfer    = sg2dl_vld && dl_rdy;
    assign wt_cnt_inc = wt_cnt + CNT_W'(wt_xfer);
    assign dl_cnt_inc = dl_cnt + CNT_W'(dl_xfer);

    always_comb begin
        state_nxt = state;
        latch_cfg = 1'b0;
        grp_adv   = 1'b0;
        pend_set  = 1'b0;
        fifo_set  = 1'b0;
        done_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (csc_state == CSC_PEND) begin
                    state_nxt = S_PEND;
                end else if (csc_busy) begin
                    latch_cfg = 1'b1;
                    state_nxt = S_WT;
                end
            end
            S_PEND: begin
                pend_set = cbuf_pend_ack && !ack_seen;
                if (csc_busy && (ack_seen || cbuf_pend_ack)) begin
                    latch_cfg = 1'b1;
                    state_nxt = S_WT;
                end
            end
            S_WT: begin
                if (!csc_busy || (cfg_groups_q == '0)) begin
                    state_nxt = S_DRAIN;
                end else if (wt_cnt_inc >= cfg_wt_q) begin
                    state_nxt = S_DL;
                end
            end
            S_DL: begin
                if (!csc_busy) begin
                    state_nxt = S_DRAIN;
                end else if (dl_cnt_inc >= cfg_dl_q) begin
                    if (({1'b0, grp_cnt} + (CNT_W+1)'(1)) < {1'b0, cfg_groups_q}) begin
                        grp_adv   = 1'b1;
                        state_nxt = S_WT;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (credit == CREDIT_W'(CREDIT_MAX)) begin
                    fifo_set  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // fifo_clr is still high on the first S_DONE cycle; hold done off to keep a gap.
                if ((csc_state == CSC_DONE) && (cacc_done || cacc_done_seen) && !fifo_clr) begin
                    done_set  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wt_cnt         <= '0;
            dl_cnt         <= '0;
            grp_cnt        <= '0;
            cfg_groups_q   <= '0;
            cfg_wt_q       <= '0;
            cfg_dl_q       <= '0;
            ack_seen       <= 1'b0;
            cacc_done_seen <= 1'b0;
            pending_clr    <= 1'b0;
            fifo_clr       <= 1'b0;
            done           <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending_clr <= pend_set;
            fifo_clr    <= fifo_set;
            done        <= done_set;
            if (latch_cfg) begin
                cfg_groups_q <= cfg_groups;
                cfg_wt_q     <= cfg_wt_atoms;
                cfg_dl_q     <= cfg_dl_atoms;
                grp_cnt      <= '0;
                wt_cnt       <= '0;
                dl_cnt       <= '0;
            end else if (grp_adv) begin
                grp_cnt <= grp_cnt + CNT_W'(1);
                wt_cnt  <= '0;
                dl_cnt  <= '0;
            end else begin
                wt_cnt <= wt_cnt_inc;
                dl_cnt <= dl_cnt_inc;
            end
            ack_seen       <= (state == S_PEND) && (state_nxt == S_PEND) && (ack_seen || cbuf_pend_ack);
            cacc_done_seen <= (state != S_IDLE) && !done_set && (cacc_done_seen || cacc_done);
        end
    end

endmodule
